// File: rtl/checker_pkg.sv
// Shared types for the in-order commit checker: FSM state encoding and one
// expected-result table entry.
package checker_pkg;

    localparam int unsigned CHK_DATA_W = 32;
    localparam int unsigned CHK_REG_AW = 4;

    typedef enum logic [2:0] {
        CHK_IDLE    = 3'd0,
        CHK_RUN     = 3'd1,
        CHK_PASS    = 3'd2,
        CHK_FAIL    = 3'd3,
        CHK_TIMEOUT = 3'd4
    } chk_state_t;

    typedef struct packed {
        logic [CHK_REG_AW-1:0] rd;
        logic [CHK_DATA_W-1:0] data;
    } exp_entry_t;

endpackage

// File: rtl/pc_trace_buffer.sv
// Circular PC history: one entry written per enabled cycle, read back by age
// (rd_idx_i = 0 is the most recent write). Used only with CHECKER_PC_TRACE_EN.
module pc_trace_buffer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_i,
    input  logic                           wr_en_i,
    input  logic [DATA_W-1:0]              pc_i,
    input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx_i,
    output logic [DATA_W-1:0]              rd_pc_o
);

    localparam int unsigned TW = $clog2(TRACE_DEPTH);

    logic [DATA_W-1:0] mem_q [TRACE_DEPTH];
    logic [TW-1:0]     wptr_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wptr_q <= '0;
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wptr_q] <= pc_i;
            wptr_q        <= wptr_q + TW'(1);
        end
    end

    // Power-of-two depth lets the pointer arithmetic wrap for free.
    assign rd_pc_o = mem_q[wptr_q - TW'(1) - rd_idx_i];

endmodule

// File: rtl/pipeline_commit_checker.sv
// In-order commit checker: compares each writeback against a programmed table,
// counts cycles/retirements/stores, reports PASS/FAIL/TIMEOUT. CHECKER_PC_TRACE_EN adds a PC trace.
module pipeline_commit_checker
    import checker_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned NUM_CHECKS  = 8,
    parameter int unsigned TIMEOUT     = 256,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            switchStart,
    input  logic                            wb_valid,
    input  logic [REG_AW-1:0]               wb_rd,
    input  logic [DATA_W-1:0]               wb_data,
    input  logic                            mem_we,
    input  logic [DATA_W-1:0]               pc,
    input  logic                            exp_wr,
    input  logic [$clog2(NUM_CHECKS)-1:0]   exp_idx,
    input  logic [REG_AW-1:0]               exp_rd,
    input  logic [DATA_W-1:0]               exp_data,
    input  logic [$clog2(NUM_CHECKS+1)-1:0] num_checks,
    output logic [2:0]                      state_o,
    output logic                            done,
    output logic                            pass,
    output logic [CNT_W-1:0]                cycle_cnt,
    output logic [CNT_W-1:0]                retire_cnt,
    output logic [CNT_W-1:0]                store_cnt,
    output logic [$clog2(NUM_CHECKS)-1:0]   fail_idx,
    output logic [REG_AW-1:0]               fail_rd,
    output logic [DATA_W-1:0]               fail_data,
    input  logic [$clog2(TRACE_DEPTH)-1:0]  trace_idx,
    output logic [DATA_W-1:0]               trace_pc
);

    localparam int unsigned IW = $clog2(NUM_CHECKS);
    localparam int unsigned CW = $clog2(NUM_CHECKS + 1);
    localparam int unsigned WW = $clog2(TIMEOUT);

    chk_state_t        state_q;
    logic              start_q;
    exp_entry_t        tbl_q [NUM_CHECKS];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     ptr_q;
    logic [WW-1:0]     wd_q;
    logic [CNT_W-1:0]  cycle_cnt_q, retire_cnt_q, store_cnt_q;
    logic [IW-1:0]     fail_idx_q;
    logic [REG_AW-1:0] fail_rd_q;
    logic [DATA_W-1:0] fail_data_q;

    logic       start_edge, run_active, wb_match;
    logic [CW-1:0] count_clamped;
    exp_entry_t cur_exp;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    assign start_edge    = switchStart && !start_q;
    assign run_active    = (state_q == CHK_RUN) && switchStart;
    assign cur_exp       = tbl_q[ptr_q[IW-1:0]];
    assign wb_match      = (CHK_REG_AW'(wb_rd) == cur_exp.rd) && (CHK_DATA_W'(wb_data) == cur_exp.data);
    assign count_clamped = (num_checks > CW'(NUM_CHECKS)) ? CW'(NUM_CHECKS) : num_checks;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CHK_IDLE;
            // NOTE: previous-start flag resets high so a switch already held high needs a fresh 0->1 edge.
            start_q      <= 1'b1;
            count_q      <= '0;
            ptr_q        <= '0;
            wd_q         <= '0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            store_cnt_q  <= '0;
            fail_idx_q   <= '0;
            fail_rd_q    <= '0;
            fail_data_q  <= '0;
            // NOTE: the table is small register storage, so it is cleared on reset like any other state.
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            start_q <= switchStart;
            unique case (state_q)
                CHK_IDLE: begin
                    if (exp_wr) begin
                        tbl_q[exp_idx] <= '{rd: CHK_REG_AW'(exp_rd), data: CHK_DATA_W'(exp_data)};
                    end
                    if (start_edge) begin
                        state_q      <= CHK_RUN;
                        count_q      <= count_clamped;
                        ptr_q        <= '0;
                        wd_q         <= '0;
                        cycle_cnt_q  <= '0;
                        retire_cnt_q <= '0;
                        store_cnt_q  <= '0;
                        fail_idx_q   <= '0;
                        fail_rd_q    <= '0;
                        fail_data_q  <= '0;
                    end
                end
                CHK_RUN: begin
                    if (!switchStart) begin
                        state_q <= CHK_IDLE;
                    end else begin
                        cycle_cnt_q  <= sat_inc(cycle_cnt_q, 1'b1);
                        retire_cnt_q <= sat_inc(retire_cnt_q, wb_valid);
                        store_cnt_q  <= sat_inc(store_cnt_q, mem_we);
                        wd_q         <= wb_valid ? '0 : wd_q + WW'(1);
                        if (count_q == '0) begin
                            state_q <= CHK_PASS;
                        end else if (wb_valid && (ptr_q < count_q)) begin
                            if (wb_match) begin
                                ptr_q <= ptr_q + CW'(1);
                                if (ptr_q + CW'(1) == count_q) begin
                                    state_q <= CHK_PASS;
                                end
                            end else begin
                                state_q     <= CHK_FAIL;
                                fail_idx_q  <= ptr_q[IW-1:0];
                                fail_rd_q   <= wb_rd;
                                fail_data_q <= wb_data;
                            end
                        end else if (!wb_valid && (wd_q == WW'(TIMEOUT - 2))) begin
                            state_q <= CHK_TIMEOUT;
                        end
                    end
                end
                default: begin
                    if (!switchStart) begin
                        state_q <= CHK_IDLE;
                    end
                end
            endcase
        end
    end

    assign state_o    = state_q;
    assign done       = state_q inside {CHK_PASS, CHK_FAIL, CHK_TIMEOUT};
    assign pass       = (state_q == CHK_PASS);
    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
    assign store_cnt  = store_cnt_q;
    assign fail_idx   = fail_idx_q;
    assign fail_rd    = fail_rd_q;
    assign fail_data  = fail_data_q;

`ifdef CHECKER_PC_TRACE_EN
    pc_trace_buffer #(
        .DATA_W      (DATA_W),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk      (clk),
        .rst      (rst),
        .clear_i  ((state_q == CHK_IDLE) && start_edge),
        .wr_en_i  (run_active),
        .pc_i     (pc),
        .rd_idx_i (trace_idx),
        .rd_pc_o  (trace_pc)
    );
`else
    logic unused_trace;
    assign unused_trace = ^{pc, trace_idx, run_active};
    assign trace_pc     = '0;
`endif

endmodule

// File: tb/tb_pipeline_commit_checker.sv
// Directed bench for pipeline_commit_checker: a cycle-level reference model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_pipeline_commit_checker;

    localparam int TIMEOUT     = 16;
    localparam int TRACE_DEPTH = 8;
    localparam int S_IDLE = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3, S_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst, switchStart, wb_valid, mem_we, exp_wr;
    logic [3:0]  wb_rd, exp_rd, num_checks, fail_rd;
    logic [31:0] wb_data, pc, exp_data;
    logic [2:0]  exp_idx, trace_idx, state_o, fail_idx;
    logic        done, pass;
    logic [31:0] cycle_cnt, retire_cnt, store_cnt, fail_data, trace_pc;

    int total = 0;
    int bad   = 0;

    pipeline_commit_checker #(
        .DATA_W(32), .REG_AW(4), .NUM_CHECKS(8), .TIMEOUT(TIMEOUT), .CNT_W(32), .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .switchStart(switchStart), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .mem_we(mem_we), .pc(pc), .exp_wr(exp_wr), .exp_idx(exp_idx),
        .exp_rd(exp_rd), .exp_data(exp_data), .num_checks(num_checks), .state_o(state_o),
        .done(done), .pass(pass), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .store_cnt(store_cnt), .fail_idx(fail_idx), .fail_rd(fail_rd), .fail_data(fail_data),
        .trace_idx(trace_idx), .trace_pc(trace_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
    } ent_t;

    bit          m_valid = 1'b0;
    int          m_state;
    bit          m_prev_sw;
    logic [3:0]  m_tbl_rd   [8];
    logic [31:0] m_tbl_data [8];
    ent_t        m_exp [$];
    int          m_need, m_matched, m_since;
    longint      m_cyc, m_ret, m_sto;
    int          m_fidx;
    logic [3:0]  m_frd;
    logic [31:0] m_fdata;
    logic [31:0] m_trace [$];

    function automatic longint sat(input longint v);
        return (v >= longint'(32'hFFFF_FFFF)) ? v : v + 1;
    endfunction

    function automatic logic [31:0] exp_trace();
`ifdef CHECKER_PC_TRACE_EN
        return (int'(trace_idx) < m_trace.size()) ? m_trace[trace_idx] : 32'd0;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_clear_results();
        m_cyc = 0; m_ret = 0; m_sto = 0;
        m_fidx = 0; m_frd = '0; m_fdata = '0;
        m_matched = 0; m_since = 0;
        m_trace.delete();
    endtask

    // Predicts the state after the coming rising edge from the inputs it will sample.
    task automatic model_step();
        if (rst) begin
            m_state = S_IDLE; m_prev_sw = 1'b1; m_need = 0;
            for (int i = 0; i < 8; i++) begin
                m_tbl_rd[i] = '0; m_tbl_data[i] = '0;
            end
            m_exp.delete();
            model_clear_results();
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_state)
                S_IDLE: begin
                    if (exp_wr) begin
                        m_tbl_rd[exp_idx] = exp_rd; m_tbl_data[exp_idx] = exp_data;
                    end
                    if (switchStart && !m_prev_sw) begin
                        m_state = S_RUN;
                        m_need  = (num_checks > 4'd8) ? 8 : int'(num_checks);
                        m_exp.delete();
                        for (int i = 0; i < m_need; i++) m_exp.push_back('{m_tbl_rd[i], m_tbl_data[i]});
                        model_clear_results();
                    end
                end
                S_RUN: begin
                    if (!switchStart) begin
                        m_state = S_IDLE;
                    end else begin
                        m_cyc = sat(m_cyc);
                        if (wb_valid) m_ret = sat(m_ret);
                        if (mem_we) m_sto = sat(m_sto);
                        m_trace.push_front(pc);
                        if (m_trace.size() > TRACE_DEPTH) void'(m_trace.pop_back());
                        m_since = wb_valid ? 0 : m_since + 1;
                        if (m_need == 0) begin
                            m_state = S_PASS;
                        end else if (wb_valid) begin
                            if (wb_rd == m_exp[m_matched].rd && wb_data == m_exp[m_matched].data) begin
                                m_matched++;
                                if (m_matched == m_need) m_state = S_PASS;
                            end else begin
                                m_state = S_FAIL; m_fidx = m_matched; m_frd = wb_rd; m_fdata = wb_data;
                            end
                        end else if (m_since == TIMEOUT - 1) begin
                            m_state = S_TIMEOUT;
                        end
                    end
                end
                default: if (!switchStart) m_state = S_IDLE;
            endcase
            m_prev_sw = switchStart;
        end
    endtask

    // Inputs change only 2 time units after a rising edge, so at the falling
    // edge they already hold the values the next rising edge will sample.
    always @(negedge clk) begin
        if (m_valid) begin
            check("m_state", state_o, m_state);
            check("m_done", done, (m_state >= S_PASS));
            check("m_pass", pass, (m_state == S_PASS));
            check("m_cycle_cnt", cycle_cnt, m_cyc);
            check("m_retire_cnt", retire_cnt, m_ret);
            check("m_store_cnt", store_cnt, m_sto);
            check("m_fail_idx", fail_idx, m_fidx);
            check("m_fail_rd", fail_rd, m_frd);
            check("m_fail_data", fail_data, m_fdata);
            check("m_trace_pc", trace_pc, exp_trace());
        end
        model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_wb(input int rd, input int data);
        wb_valid = 1'b1; wb_rd = 4'(rd); wb_data = 32'(data);
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic program_entry(input int idx, input int rd, input int data);
        exp_wr = 1'b1; exp_idx = 3'(idx); exp_rd = 4'(rd); exp_data = 32'(data);
        tick();
        exp_wr = 1'b0;
    endtask

    task automatic start_run();
        switchStart = 1'b0; tick();
        switchStart = 1'b1; tick();
    endtask

    task automatic stop_run();
        switchStart = 1'b0; tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; switchStart = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        mem_we = 1'b0; pc = '0; exp_wr = 1'b0; exp_idx = '0; exp_rd = '0; exp_data = '0;
        num_checks = '0; trace_idx = '0;
        repeat (3) tick();
        rst = 1'b0;
        at_neg();
        check("reset_state", state_o, 3'd0);
        check("reset_cycle_cnt", cycle_cnt, 32'd0);

        // 1: three matching writebacks
        program_entry(0, 2, 8);
        program_entry(1, 4, 11);
        program_entry(2, 6, 18);
        num_checks = 4'd3;
        start_run();
        do_wb(2, 8);
        mem_we = 1'b1;
        do_wb(4, 11);
        mem_we = 1'b0;
        do_wb(6, 18);
        at_neg();
        check("t1_pass", pass, 1'b1);
        check("t1_state", state_o, 3'd2);
        check("t1_retire", retire_cnt, 32'd3);
        check("t1_store", store_cnt, 32'd1);
        check("t1_cycles", cycle_cnt, 32'd3);
        stop_run();
        at_neg();
        check("t1_idle_keeps_retire", retire_cnt, 32'd3);

        // 2: mismatch on the second writeback
        start_run();
        do_wb(2, 8);
        do_wb(4, 12);
        do_wb(6, 18);
        at_neg();
        check("t2_state", state_o, 3'd3);
        check("t2_fail_idx", fail_idx, 3'd1);
        check("t2_fail_rd", fail_rd, 4'd4);
        check("t2_fail_data", fail_data, 32'd12);
        check("t2_retire", retire_cnt, 32'd2);

        // 3: one writeback then silence
        start_run();
        do_wb(2, 8);
        repeat (14) tick();
        at_neg();
        check("t3_still_run", state_o, 3'd1);
        tick();
        at_neg();
        check("t3_timeout", state_o, 3'd4);
        check("t3_cycles", cycle_cnt, 32'd16);
        repeat (3) tick();
        at_neg();
        check("t3_cycles_frozen", cycle_cnt, 32'd16);

        // 4: writeback on the exact expiry cycle
        start_run();
        do_wb(2, 8);
        repeat (14) tick();
        do_wb(4, 11);
        at_neg();
        check("t4_saved", state_o, 3'd1);
        repeat (14) tick();
        at_neg();
        check("t4_restart_run", state_o, 3'd1);
        tick();
        at_neg();
        check("t4_timeout", state_o, 3'd4);
        check("t4_cycles", cycle_cnt, 32'd31);

        // 5: zero checks, then table writes during RUN are ignored
        num_checks = 4'd0;
        start_run();
        at_neg();
        check("t5_run", state_o, 3'd1);
        tick();
        at_neg();
        check("t5_pass", pass, 1'b1);
        check("t5_cycles", cycle_cnt, 32'd1);
        num_checks = 4'd1;
        start_run();
        program_entry(0, 9, 99);
        do_wb(2, 8);
        at_neg();
        check("t5_table_unchanged", state_o, 3'd2);

        // clamp: num_checks above table depth uses all 8 entries
        stop_run();
        for (int i = 3; i < 8; i++) program_entry(i, i, 100 + i);
        num_checks = 4'd15;
        start_run();
        do_wb(2, 8);
        do_wb(4, 11);
        do_wb(6, 18);
        for (int i = 3; i < 7; i++) do_wb(i, 100 + i);
        at_neg();
        check("clamp_seven_run", state_o, 3'd1);
        do_wb(7, 107);
        at_neg();
        check("clamp_pass", state_o, 3'd2);
        check("clamp_retire", retire_cnt, 32'd8);

        // PC trace: 10 RUN cycles into an 8-deep buffer
        num_checks = 4'd3;
        start_run();
        for (int k = 0; k < 10; k++) begin
            pc = 32'h100 + 32'(4 * k);
            tick();
        end
        stop_run();
        trace_idx = 3'd0;
        at_neg();
`ifdef CHECKER_PC_TRACE_EN
        check("trace_newest", trace_pc, 32'h124);
`else
        check("trace_tied_off", trace_pc, 32'h0);
`endif
        trace_idx = 3'd7;
        at_neg();
`ifdef CHECKER_PC_TRACE_EN
        check("trace_oldest_wrap", trace_pc, 32'h108);
`else
        check("trace_tied_off_7", trace_pc, 32'h0);
`endif
        for (int i = 1; i < 7; i++) begin
            trace_idx = 3'(i);
            at_neg();
        end
        trace_idx = 3'd0;

        // 6: reset in the middle of RUN
        start_run();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        at_neg();
        check("t6_state", state_o, 3'd0);
        check("t6_done", done, 1'b0);
        check("t6_cycles", cycle_cnt, 32'd0);
        check("t6_retire", retire_cnt, 32'd0);
        check("t6_fail_data", fail_data, 32'd0);
        check("t6_trace", trace_pc, 32'd0);
        repeat (3) tick();
        at_neg();
        check("t6_level_high_idle", state_o, 3'd0);
        switchStart = 1'b0; tick();
        switchStart = 1'b1; tick();
        at_neg();
        check("t6_edge_run", state_o, 3'd1);
        stop_run();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
